// File: rtl/instr_mem_responder_if.sv
// Instruction-fetch bus between the core fetch stage (master) and the memory responder (slave).
// Latency: none, plain wires.
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
interface instr_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic        rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_instr, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_instr, rsp_err
   );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction RAM responder: returns the word at each fetched PC, or NOP_INSTR with rsp_err on a bad PC.
// Latency: response visible LATENCY edges after the accept edge when nothing is queued ahead of it.
// Backpressure: credit count of outstanding fetches; req_ready drops once QDEPTH are in flight.
module instr_mem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter int          QDEPTH      = 4,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic                           clk,
   input  logic                           rst_n,
   instr_mem_responder_if.slave           bus,
   input  logic                           ld_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
   input  logic [31:0]                    ld_data
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [PW-1:0] QLAST = PW'(QDEPTH - 1);
   localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

   logic [31:0]        mem [DEPTH_WORDS];
   logic [LATENCY-1:0] pv;                 // pipeline stage holds a fetch
   logic [LATENCY-1:0] pe;                 // pipeline stage fetch is an error
   logic [31:0]        pd [LATENCY];       // pipeline stage RAM data

   logic [31:0]        q_dat [QDEPTH];
   logic               q_err [QDEPTH];
   logic [PW-1:0]      wptr, rptr;
   logic [CW-1:0]      qcnt;
   logic [CW-1:0]      cnt, cnt_nxt;

   logic               rdy, vld, err_r;
   logic [31:0]        instr_r;

   logic               acc, req_err, pop, slot_free, q_empty;
   logic               in_vld, in_err, ld_q, ld_in, push;
   logic [31:0]        in_dat;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == QLAST) ? '0 : p + 1'b1;
   endfunction

   assign bus.req_ready = rdy;
   assign bus.rsp_valid = vld;
   assign bus.rsp_instr = instr_r;
   assign bus.rsp_err   = err_r;

   assign acc       = bus.req_valid && rdy;
   assign req_err   = (bus.req_addr[1:0] != 2'b00) || (|bus.req_addr[31:AW+2]);
   assign pop       = vld && bus.rsp_ready;
   assign slot_free = !vld || bus.rsp_ready;
   assign q_empty   = (qcnt == '0);
   assign in_vld    = pv[LATENCY-1];
   assign in_err    = pe[LATENCY-1];
   assign in_dat    = in_err ? NOP_INSTR : pd[LATENCY-1];
   // Older queued entries always go to the output before a newly arriving one.
   assign ld_q      = slot_free && !q_empty;
   assign ld_in     = slot_free && q_empty && in_vld;
   assign push      = in_vld && !ld_in;

   // Outstanding count: +1 per accept, -1 per response handshake.
   always_comb begin
      cnt_nxt = cnt;
      if (acc && !pop)
         cnt_nxt = cnt + 1'b1;
      else if (!acc && pop)
         cnt_nxt = cnt - 1'b1;
   end

   // RAM preload port plus registered read; the read sees the pre-write word on a same-edge collision.
   always_ff @(posedge clk) begin
      if (ld_en)
         mem[ld_addr] <= ld_data;
      if (acc && !req_err)
         pd[0] <= mem[bus.req_addr[2 +: AW]];
      for (int i = 1; i < LATENCY; i++)
         pd[i] <= pd[i-1];
   end

   // Response queue storage; only pointers and occupancy need reset.
   always_ff @(posedge clk) begin
      if (push) begin
         q_dat[wptr] <= in_dat;
         q_err[wptr] <= in_err;
      end
   end

   // Control: pipeline valids, queue pointers, credit count and the registered response slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv      <= '0;
         pe      <= '0;
         wptr    <= '0;
         rptr    <= '0;
         qcnt    <= '0;
         cnt     <= '0;
         rdy     <= 1'b0;
         vld     <= 1'b0;
         err_r   <= 1'b0;
         instr_r <= '0;
      end else begin
         pv  <= (pv << 1) | LATENCY'(acc);
         pe  <= (pe << 1) | LATENCY'(acc && req_err);
         cnt <= cnt_nxt;
         rdy <= (cnt_nxt < QFULL);
         if (push)
            wptr <= ptr_inc(wptr);
         if (ld_q)
            rptr <= ptr_inc(rptr);
         if (push && !ld_q)
            qcnt <= qcnt + 1'b1;
         else if (!push && ld_q)
            qcnt <= qcnt - 1'b1;
         if (ld_q) begin
            vld     <= 1'b1;
            instr_r <= q_dat[rptr];
            err_r   <= q_err[rptr];
         end else if (ld_in) begin
            vld     <= 1'b1;
            instr_r <= in_dat;
            err_r   <= in_err;
         end else if (pop) begin
            vld <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized scoreboard bench for instr_mem_responder.
// Expected words come from a model RAM; expected timing from accept edge and previous handshake.
// Checks are made at the falling edge; stimulus is driven 1 time unit after the rising edge.
module tb_instr_mem_responder;
   localparam int          DW  = 1024;
   localparam int          AW  = 10;
   localparam int          LAT = 2;
   localparam int          QD  = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      int          acc;     // rising-edge number on which the request was accepted
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [31:0]   ld_data = '0;

   instr_mem_responder_if bus();

   instr_mem_responder #(
      .DEPTH_WORDS(DW), .LATENCY(LAT), .QDEPTH(QD), .NOP_INSTR(NOP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   bit          seen_edge = 1'b0;
   bit          rand_mode = 1'b0;
   exp_t        exp_q [$];
   logic [31:0] mm [DW];
   int          cnt_m = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) seen_edge <= 1'b0;
      else        seen_edge <= 1'b1;
   end

   // Request-side monitor: credit model, expected-response generation, model RAM writes.
   exp_t        ein;
   int unsigned widx;
   always @(negedge clk) begin
      if (!rst_n) begin
         cnt_m = 0;
      end else begin
         chk("req_ready", {31'b0, bus.req_ready}, {31'b0, (seen_edge && cnt_m < QD)});
         if (bus.req_valid && bus.req_ready) begin
            widx      = bus.req_addr >> 2;
            ein.err   = (bus.req_addr[1:0] != 2'b00) || (widx >= DW);
            ein.instr = ein.err ? NOP : mm[widx];
            ein.acc   = cyc + 1;
            exp_q.push_back(ein);
            cnt_m++;
         end
         if (bus.rsp_valid && bus.rsp_ready) cnt_m--;
         if (ld_en) mm[ld_addr] = ld_data;
      end
   end

   // Response-side monitor: pops the scoreboard and checks data, error flag, timing and holding.
   exp_t        eh;
   bit          prev_vld = 1'b0, prev_hs = 1'b0;
   logic [31:0] held_instr = '0, last_instr = '0;
   logic        held_err = 1'b0;
   int          last_hs_edge = 0;
   int          t_exp;
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
         chk("rst_rsp_instr", bus.rsp_instr, 32'd0);
         chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
         chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
         exp_q.delete();
         prev_vld = 1'b0; prev_hs = 1'b0;
         last_instr = '0; last_hs_edge = 0;
      end else begin
         if (bus.rsp_valid) begin
            if (!prev_vld || prev_hs) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_rsp: got instr %h with no fetch outstanding (cycle %0d)", bus.rsp_instr, cyc);
               end else begin
                  eh    = exp_q[0];
                  t_exp = (eh.acc + LAT > last_hs_edge) ? eh.acc + LAT : last_hs_edge;
                  chk("rsp_timing", cyc, t_exp);
                  chk("rsp_instr", bus.rsp_instr, eh.instr);
                  chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, eh.err});
               end
            end else begin
               chk("hold_instr", bus.rsp_instr, held_instr);
               chk("hold_err", {31'b0, bus.rsp_err}, {31'b0, held_err});
            end
            if (bus.rsp_ready) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               last_hs_edge = cyc + 1;
            end
            held_instr = bus.rsp_instr;
            held_err   = bus.rsp_err;
            last_instr = bus.rsp_instr;
         end else begin
            chk("idle_instr", bus.rsp_instr, last_instr);
         end
         prev_vld = bus.rsp_valid;
         prev_hs  = bus.rsp_valid && bus.rsp_ready;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      if (rand_mode) bus.rsp_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic load(input int idx, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = AW'(idx); ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic issue(input logic [31:0] a);
      bit acc;
      int t;
      bus.req_valid = 1'b1; bus.req_addr = a;
      acc = 1'b0; t = 0;
      while (!acc && t < 64) begin
         @(negedge clk);
         acc = bus.req_ready;
         tick();
         t++;
      end
      if (!acc) begin
         n_cmp++; n_bad++;
         $display("FAIL issue_timeout: addr %h never accepted", a);
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      bus.rsp_ready = 1'b1; bus.req_valid = 1'b0;
      while (exp_q.size() != 0 && t < 100) begin
         tick();
         t++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: %0d responses still missing", exp_q.size());
      end
      repeat (2) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      int r;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0;

      // Reset held for three cycles.
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) tick();

      // Streaming fetch of eight preloaded words.
      for (int i = 0; i < 8; i++) load(i, 32'hA000_0000 + 32'(i));
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) issue(32'(i * 4));
      drain();

      // Back-pressure: six requests against a stalled consumer.
      bus.rsp_ready = 1'b0;
      fork
         for (int i = 0; i < 6; i++) issue(32'(i * 4));
         begin
            repeat (12) @(posedge clk);
            #1 bus.rsp_ready = 1'b1;
         end
      join
      drain();

      // Misaligned, out-of-range, then a good fetch.
      issue(32'h0000_0002);
      issue(32'(DW * 4));
      issue(32'h0000_0004);
      drain();

      // Fetch and preload of the same word on the same edge.
      load(3, 32'h1111_1111);
      ld_en = 1'b1; ld_addr = AW'(3); ld_data = 32'h2222_2222;
      issue(32'h0000_000C);
      ld_en = 1'b0;
      issue(32'h0000_000C);
      drain();

      // Reset with three fetches outstanding.
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) issue(32'(i * 4));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      repeat (10) tick();
      issue(32'h0000_0008);
      drain();

      // Randomized traffic with random consumer stalls and concurrent preloads.
      for (int i = 0; i < 16; i++) load(i, $urandom());
      rand_mode = 1'b1;
      for (int k = 0; k < 200; k++) begin
         r = $urandom_range(0, 9);
         if ($urandom_range(0, 3) == 0) begin
            ld_en = 1'b1; ld_addr = AW'($urandom_range(0, 15)); ld_data = $urandom();
         end
         if (r < 7) begin
            a = 32'($urandom_range(0, 15)) << 2;
            issue(a);
         end else if (r == 7) begin
            a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            issue(a);
         end else if (r == 8) begin
            a = ($urandom() & 32'hFFFF_FFFC) | (32'(DW) << 2);
            issue(a);
         end else begin
            tick();
         end
         ld_en = 1'b0;
      end
      rand_mode = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
